// File: rtl/alien_grid_scan.sv
// alien_grid_scan: sequential laser-vs-formation collision scanner, one alien per cycle,
// bottom row first, returning the first live alien hit and the updated alive mask.
module alien_grid_scan #(
    parameter int ALIEN_WIDTH  = 40,
    parameter int ALIEN_HEIGHT = 21,
    parameter int ALIEN_GAP    = 21,
    parameter int ALIEN_VGAP   = 21,
    parameter int LASER_WIDTH  = 5,
    parameter int NUM_COLS     = 5,
    parameter int NUM_ROWS     = 4,
    localparam int N  = NUM_ROWS * NUM_COLS,
    localparam int IW = $clog2(N),
    localparam int RW = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1,
    localparam int CW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [9:0]    laser_x,
    input  logic [8:0]    laser_y,
    input  logic [9:0]    group_x,
    input  logic [8:0]    group_y,
    input  logic [N-1:0]  alive_in,
    output logic          busy,
    output logic          done,
    output logic          hit,
    output logic [IW-1:0] hit_index,
    output logic [RW-1:0] hit_row,
    output logic [CW-1:0] hit_col,
    output logic [N-1:0]  alive_out
);
    localparam int XS = ALIEN_WIDTH + ALIEN_GAP;
    localparam int YS = ALIEN_HEIGHT + ALIEN_VGAP;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, hit_index_q, hit_index_d;
    logic [RW-1:0] row_q, row_d, hit_row_q, hit_row_d;
    logic [CW-1:0] col_q, col_d, hit_col_q, hit_col_d;
    logic [9:0]    lx_q, lx_d, gx_q, gx_d;
    logic [8:0]    ly_q, ly_d, gy_q, gy_d;
    logic [N-1:0]  mask_q, mask_d, alive_out_q, alive_out_d;
    logic          hit_q, hit_d;
    logic [10:0]   x0, y0;
    logic          overlap, hit_now;

    // Row/col walk alongside idx so no divider is needed for the geometry.
    always_comb begin
        x0      = 11'(gx_q) + 11'(int'(col_q) * XS);
        y0      = 11'(gy_q) + 11'(int'(row_q) * YS);
        overlap = (11'(lx_q) + 11'(LASER_WIDTH) > x0) && (11'(lx_q) < x0 + 11'(ALIEN_WIDTH)) &&
                  (11'(ly_q) >= y0) && (11'(ly_q) < y0 + 11'(ALIEN_HEIGHT));
        hit_now = mask_q[idx_q] && overlap;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        lx_d        = lx_q;
        ly_d        = ly_q;
        gx_d        = gx_q;
        gy_d        = gy_q;
        mask_d      = mask_q;
        hit_d       = hit_q;
        hit_index_d = hit_index_q;
        hit_row_d   = hit_row_q;
        hit_col_d   = hit_col_q;
        alive_out_d = alive_out_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SCAN;
                idx_d   = IW'(N - 1);
                row_d   = RW'(NUM_ROWS - 1);
                col_d   = CW'(NUM_COLS - 1);
                lx_d    = laser_x;
                ly_d    = laser_y;
                gx_d    = group_x;
                gy_d    = group_y;
                mask_d  = alive_in;
                hit_d   = 1'b0;
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hit_now) begin
                    state_d     = DONE;
                    hit_d       = 1'b1;
                    hit_index_d = idx_q;
                    hit_row_d   = row_q;
                    hit_col_d   = col_q;
                    alive_out_d = mask_q & ~(N'(1) << idx_q);
                end else if (idx_q == '0) begin
                    state_d     = DONE;
                    hit_d       = 1'b0;
                    alive_out_d = mask_q;
                end else begin
                    idx_d = idx_q - 1'b1;
                    col_d = (col_q == '0) ? CW'(NUM_COLS - 1) : col_q - 1'b1;
                    row_d = (col_q == '0) ? row_q - 1'b1 : row_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= IW'(N - 1);
            row_q       <= RW'(NUM_ROWS - 1);
            col_q       <= CW'(NUM_COLS - 1);
            lx_q        <= '0;
            ly_q        <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            mask_q      <= '0;
            hit_q       <= 1'b0;
            hit_index_q <= '0;
            hit_row_q   <= '0;
            hit_col_q   <= '0;
            alive_out_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            lx_q        <= lx_d;
            ly_q        <= ly_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            mask_q      <= mask_d;
            hit_q       <= hit_d;
            hit_index_q <= hit_index_d;
            hit_row_q   <= hit_row_d;
            hit_col_q   <= hit_col_d;
            alive_out_q <= alive_out_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign hit       = hit_q;
    assign hit_index = hit_index_q;
    assign hit_row   = hit_row_q;
    assign hit_col   = hit_col_q;
    assign alive_out = alive_out_q;
endmodule

// File: tb/tb_alien_grid_scan.sv
// tb_alien_grid_scan: directed and randomized scans checked against a geometric reference model.
module tb_alien_grid_scan;
    localparam int AW = 40, AH = 21, AG = 21, AV = 21, LW = 5, NC = 5, NR = 4, N = NC * NR;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [9:0]    laser_x = '0, group_x = '0;
    logic [8:0]    laser_y = '0, group_y = '0;
    logic [N-1:0]  alive_in = '0;
    logic          busy, done, hit;
    logic [4:0]    hit_index;
    logic [1:0]    hit_row;
    logic [2:0]    hit_col;
    logic [N-1:0]  alive_out;

    int checks = 0, errors = 0;
    int prev_idx = 0, prev_row = 0, prev_col = 0;
    logic [N-1:0] prev_alive = '0;

    alien_grid_scan dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .laser_x(laser_x), .laser_y(laser_y), .group_x(group_x), .group_y(group_y),
        .alive_in(alive_in), .busy(busy), .done(done), .hit(hit), .hit_index(hit_index),
        .hit_row(hit_row), .hit_col(hit_col), .alive_out(alive_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First live alien hit, scanning from the highest index down; -1 for a miss.
    function automatic int model(input int lx, ly, gx, gy, input logic [N-1:0] m);
        for (int k = N - 1; k >= 0; k--) begin
            int x0 = gx + (k % NC) * (AW + AG);
            int y0 = gy + (k / NC) * (AH + AV);
            if (m[k] && lx + LW > x0 && lx < x0 + AW && ly >= y0 && ly < y0 + AH) return k;
        end
        return -1;
    endfunction

    task automatic launch(input int lx, ly, gx, gy, input logic [N-1:0] m);
        @(negedge clock);
        laser_x = 10'(lx); laser_y = 9'(ly); group_x = 10'(gx); group_y = 9'(gy);
        alive_in = m; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic scan(input int lx, ly, gx, gy, input logic [N-1:0] m, input bit disturb);
        int k, n;
        bit seen;
        k = model(lx, ly, gx, gy, m);
        launch(lx, ly, gx, gy, m);
        @(negedge clock);
        chk("busy_scan", busy, 1);
        chk("hit_clr", hit, 0);
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (done) begin
                seen = 1;
                start = 1'b0;
            end else begin
                start = disturb && n == 2;
                if (disturb && n == 2) begin
                    laser_x = 10'($urandom); alive_in = N'($urandom);
                end
            end
        end
        chk("done_seen", seen, 1);
        chk("latency", n + 1, k >= 0 ? N - k + 1 : N + 1);
        if (k >= 0) begin
            prev_idx = k; prev_row = k / NC; prev_col = k % NC;
            prev_alive = m & ~(N'(1) << k);
        end else prev_alive = m;
        chk("hit", hit, k >= 0);
        chk("hit_index", hit_index, prev_idx);
        chk("hit_row", hit_row, prev_row);
        chk("hit_col", hit_col, prev_col);
        chk("alive_out", alive_out, prev_alive);
        @(negedge clock);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int gx, gy;
        bit seen;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_alive", alive_out, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        scan(280, 290, 200, 200, '1, 0);
        chk("c1_alive", alive_out, 32'hFF7FF);
        scan(250, 290, 200, 200, '1, 0);
        scan(256, 290, 200, 200, '1, 0);
        scan(257, 290, 200, 200, '1, 0);
        scan(300, 290, 200, 200, '1, 0);
        scan(301, 290, 200, 200, '1, 0);
        scan(280, 290, 200, 200, 20'hFF7FF, 0);
        scan(280, 290, 200, 200, '1, 1);
        // Abort mid-scan: no done, previous result held.
        launch(280, 290, 200, 200, '1);
        repeat (3) @(posedge clock);
        @(negedge clock) abort = 1'b1;
        @(negedge clock) abort = 1'b0;
        chk("abort_busy", busy, 0);
        seen = 0;
        repeat (25) @(negedge clock) if (done) seen = 1;
        chk("abort_nodone", seen, 0);
        chk("abort_hit", hit, 0);
        chk("abort_idx", hit_index, prev_idx);
        // Asynchronous reset mid-scan clears everything immediately.
        launch(280, 290, 200, 200, '1);
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_hit", hit, 0);
        chk("mrst_idx", hit_index, 0);
        chk("mrst_row", hit_row, 0);
        chk("mrst_col", hit_col, 0);
        chk("mrst_alive", alive_out, 0);
        @(negedge clock) reset_n = 1'b1;
        prev_idx = 0; prev_row = 0; prev_col = 0;
        for (int i = 0; i < 60; i++) begin
            gx = $urandom_range(10, 700);
            gy = $urandom_range(0, 300);
            scan(gx + $urandom_range(0, 310) - 5, gy + $urandom_range(0, 170), gx, gy,
                 N'($urandom) | N'($urandom), i % 7 == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
